prod_bin2bcd: RTL and testbench



---
 rtl/prod_bin2bcd_if.sv | 12 +
 rtl/prod_bin2bcd.sv | 87 ++++++++
 tb/tb_prod_bin2bcd.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/prod_bin2bcd_if.sv
// Start/busy/done handshake and operand/result bus of the binary-to-BCD converter.
// The master issues conversions; the slave (converter) returns the BCD result.
interface prod_bin2bcd_if;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/prod_bin2bcd.sv
// Iterative 8-bit binary to 3-digit BCD converter (shift-add-3), one bit per clock.
// A start accepted in IDLE yields a one-cycle done pulse eight edges later.
module prod_bin2bcd (
  input  logic             clk,
  input  logic             rst_n,
  prod_bin2bcd_if.slave    bus
);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  sh_reg, sh_next;
  logic [11:0] scratch_reg, scratch_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [11:0] bcd_reg, bcd_next;
  logic        done_reg, done_next;

  logic [11:0] adj;
  logic [11:0] scratch_shift;
  logic [7:0]  sh_shift;

  // Each digit is corrected on its pre-add value, independently of its neighbours.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                              ? scratch_reg[gi*4 +: 4] + 4'd3
                              : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  assign scratch_shift = {adj[10:0], sh_reg[7]};
  assign sh_shift      = {sh_reg[6:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sh_reg      <= 8'd0;
      scratch_reg <= 12'd0;
      cnt_reg     <= 3'd0;
      bcd_reg     <= 12'd0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sh_reg      <= sh_next;
      scratch_reg <= scratch_next;
      cnt_reg     <= cnt_next;
      bcd_reg     <= bcd_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sh_next      = sh_reg;
    scratch_next = scratch_reg;
    cnt_next     = cnt_reg;
    bcd_next     = bcd_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          sh_next      = bus.bin;
          scratch_next = 12'd0;
          cnt_next     = 3'd0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_next = scratch_shift;
        sh_next      = sh_shift;
        cnt_next     = cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          bcd_next   = scratch_shift;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state_reg == SHIFT);
  assign bus.done = done_reg;
  assign bus.bcd  = bcd_reg;

endmodule

// File: tb/tb_prod_bin2bcd.sv
// Self-checking bench for prod_bin2bcd: vector table, exhaustive sweep and
// handshake corner cases, with a scoreboard queue of expected results.
module tb_prod_bin2bcd;

  logic clk;
  logic rst_n;
  prod_bin2bcd_if bus ();

  prod_bin2bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp;
  } vec_t;

  function automatic logic [11:0] ref_bcd(input logic [7:0] b);
    int v;
    v = int'(b);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got bcd=%h, required no done", bus.bcd);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if (bus.bcd !== e) begin
          bad++;
          $display("FAIL bcd: got %h, required %h", bus.bcd, e);
        end else begin
          $display("done bcd=%h ok", bus.bcd);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) return;
    end
    total++;
    bad++;
    $display("FAIL timeout: got no done within 40 cycles, required done");
  endtask

  // One conversion; checks latency and the busy window. Returns aligned at posedge+1.
  task automatic do_conv(input logic [7:0] b, input logic [11:0] e);
    int n;
    int busy_cnt;
    bus.start = 1'b1;
    bus.bin   = b;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
      if (bus.busy) busy_cnt++;
    end
    check("latency", n, 9);
    check("busy_cycles", busy_cnt, 8);
    check("busy_in_done_cycle", bus.busy, 0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];

  initial begin
    int c;
    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd225, 12'h225};
    vecs[2] = '{8'd255, 12'h255};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd100, 12'h100};
    vecs[5] = '{8'd9,   12'h009};
    vecs[6] = '{8'd10,  12'h010};
    vecs[7] = '{8'd199, 12'h199};

    bus.start = 1'b0;
    bus.bin   = 8'd0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_bcd", bus.bcd, 0);
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      $display("vec %0d: bin=%0d exp=%h", i, vecs[i].bin, vecs[i].exp);
      do_conv(vecs[i].bin, vecs[i].exp);
    end

    // Exhaustive sweep against decimal digits
    for (int v = 0; v < 256; v++) begin
      do_conv(8'(v), ref_bcd(8'(v)));
    end

    // Start pulses during SHIFT are ignored; bin changes have no effect
    bus.start = 1'b1;
    bus.bin   = 8'd42;
    exp_q.push_back(12'h042);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bin   = 8'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(c);
    repeat (15) @(posedge clk);
    #1;
    check("ignored_start_queue", exp_q.size(), 0);

    // Reset mid-conversion
    bus.start = 1'b1;
    bus.bin   = 8'd200;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_busy", bus.busy, 0);
    check("midreset_done", bus.done, 0);
    check("midreset_bcd", bus.bcd, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("after_reset_bcd_held", bus.bcd, 0);
    do_conv(8'd13, 12'h013);

    // Back-to-back with start held high
    bus.start = 1'b1;
    bus.bin   = 8'd64;
    exp_q.push_back(12'h064);
    for (int k = 0; k < 4; k++) begin
      wait_done(c);
      if (k > 0) check("b2b_period", c, 9);
      if (k < 3) begin
        bus.bin = (bus.bin == 8'd64) ? 8'd81 : 8'd64;
        exp_q.push_back((bus.bin == 8'd64) ? 12'h064 : 12'h081);
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (15) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
